// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and decode helpers used by the
// timing generator and the downstream sprite/palette blocks.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Half-open window test lo <= v < hi on a 10-bit screen coordinate.
  function automatic logic in_range(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with sync, blank and frame markers
// all registered together so every output describes the same pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_W = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_W = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // After reset the first qualified cycle re-presents (0,0) with the
  // frame_start pulse instead of advancing past it.
  logic       start_pend;
  logic       h_wrap;
  logic       f_wrap;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;

  // Next-position computation
  always_comb begin
    h_wrap = (DrawX >= H_LAST);
    f_wrap = h_wrap && (DrawY >= V_LAST);
    x_nxt  = h_wrap ? 10'd0 : DrawX + 10'd1;
    y_nxt  = DrawY;
    if (h_wrap) begin
      y_nxt = (DrawY >= V_LAST) ? 10'd0 : DrawY + 10'd1;
    end
    if (start_pend) begin
      x_nxt = 10'd0;
      y_nxt = 10'd0;
    end
  end

  // Output register stage: counters and their decode update together
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
      start_pend  <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        DrawX       <= x_nxt;
        DrawY       <= y_nxt;
        hs          <= !vga_pkg::in_range(x_nxt, HS_LO, HS_HI);
        vs          <= !vga_pkg::in_range(y_nxt, VS_LO, VS_HI);
        blank       <= (x_nxt < H_ACT_W) && (y_nxt < V_ACT_W);
        frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
        start_pend  <= 1'b0;
        if (f_wrap && !start_pend) begin
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a
// tiny-raster instance for multi-frame behaviour, both against a linear-index model.
module tb_vga_timing_gen;

  localparam int SHA = 4, SHF = 1, SHS = 3, SHB = 2;
  localparam int SVA = 3, SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;   // 10
  localparam int SVT = SVA + SVF + SVS + SVB;   // 7
  localparam int SFRAME = SHT * SVT;            // 70

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn_d, pe_d, rn_s, pe_s;
  logic       hs_d, vs_d, blank_d, fs_d, hs_s, vs_s, blank_s, fs_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic [7:0] fc_d, fc_s;

  vga_timing_gen u_dut (
    .vga_clk(clk), .reset_n(rn_d), .pix_en(pe_d),
    .hs(hs_d), .vs(vs_d), .blank(blank_d), .DrawX(x_d), .DrawY(y_d),
    .frame_start(fs_d), .frame_count(fc_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_sml (
    .vga_clk(clk), .reset_n(rn_s), .pix_en(pe_s),
    .hs(hs_s), .vs(vs_s), .blank(blank_s), .DrawX(x_s), .DrawY(y_s),
    .frame_start(fs_s), .frame_count(fc_s)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: position as a linear pixel index within the frame.
  int m_idx[2];
  int m_fc[2];
  bit m_pend[2];
  bit m_fs[2];

  function automatic int fsz(input int id);
    return (id == 0) ? 800 * 525 : SFRAME;
  endfunction

  task automatic step(input int id, input bit rn, input bit pe);
    if (!rn) begin
      m_idx[id] = 0; m_fc[id] = 0; m_pend[id] = 1'b1; m_fs[id] = 1'b0;
    end else if (!pe) begin
      m_fs[id] = 1'b0;
    end else begin
      if (m_pend[id]) m_pend[id] = 1'b0;
      else begin
        m_idx[id] = (m_idx[id] + 1) % fsz(id);
        if (m_idx[id] == 0) m_fc[id] = (m_fc[id] + 1) % 256;
      end
      m_fs[id] = (m_idx[id] == 0);
    end
  endtask

  // {hs, vs, blank, DrawX, DrawY, frame_start, frame_count}
  function automatic logic [31:0] exp_vec(input int id);
    int ha, hf, hw, ht, va, vf, vw, x, y;
    logic h, v, b;
    if (id == 0) begin
      ha = 640; hf = 16; hw = 96; ht = 800; va = 480; vf = 10; vw = 2;
    end else begin
      ha = SHA; hf = SHF; hw = SHS; ht = SHT; va = SVA; vf = SVF; vw = SVS;
    end
    x = m_idx[id] % ht;
    y = m_idx[id] / ht;
    h = !(x >= ha + hf && x < ha + hf + hw);
    v = !(y >= va + vf && y < va + vf + vw);
    b = (x < ha) && (y < va);
    return {h, v, b, 10'(x), 10'(y), m_fs[id], 8'(m_fc[id])};
  endfunction

  function automatic logic [31:0] got_vec(input int id);
    if (id == 0) return {hs_d, vs_d, blank_d, x_d, y_d, fs_d, fc_d};
    return {hs_s, vs_s, blank_s, x_s, y_s, fs_s, fc_s};
  endfunction

  task automatic tick(input bit rd, input bit pd, input bit rs, input bit ps);
    rn_d = rd; pe_d = pd; rn_s = rs; pe_s = ps;
    @(posedge clk);
    #1;
    step(0, rd, pd);
    step(1, rs, ps);
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, rnd(), 1'b0, rnd());
      checks++;
      if (got_vec(0) !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL reset_state: got %h required %h", got_vec(0),
                 {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 8'd0});
      end
      checks++;
      if (got_vec(1) !== exp_vec(1)) begin
        errors++; $display("FAIL reset_state_sml: got %h required %h", got_vec(1), exp_vec(1));
      end
    end
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({x_d, y_d, blank_d, hs_d, vs_d, fs_d} !== {10'd0, 10'd0, 4'b1111}) begin
      errors++;
      $display("FAIL reset_release_first: got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b required 0 0 1 1 1 1",
               x_d, y_d, blank_d, hs_d, vs_d, fs_d);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({x_d, fs_d} !== {10'd1, 1'b0}) begin
      errors++; $display("FAIL reset_release_second: got x=%0d fs=%b required x=1 fs=0", x_d, fs_d);
    end
    checks++;
    if (got_vec(0) !== exp_vec(0)) begin
      errors++; $display("FAIL reset_release_model: got %h required %h", got_vec(0), exp_vec(0));
    end
  endtask

  task automatic test_line;
    int fall = -1, first = -1, last = -1, cnt = 0, prev = -1;
    bit wrapped = 1'b0;
    for (int i = 0; i < 1000 && !wrapped; i++) begin
      prev = int'(x_d);
      tick(1'b1, 1'b1, 1'b1, rnd());
      checks++;
      if (got_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL line_model: got %h required %h", got_vec(0), exp_vec(0));
      end
      if (x_d == 10'd0) begin
        wrapped = 1'b1;
        checks++;
        if (y_d !== 10'd1 || prev != 799) begin
          errors++; $display("FAIL line_wrap: got prev_x=%0d y=%0d required 799 1", prev, y_d);
        end
      end else begin
        if (!blank_d && fall < 0) fall = int'(x_d);
        if (!hs_d) begin
          cnt++;
          if (first < 0) first = int'(x_d);
          last = int'(x_d);
        end
      end
    end
    checks++;
    if (!wrapped) begin errors++; $display("FAIL line_timeout: got no wrap required wrap"); end
    checks++;
    if (fall != 640) begin errors++; $display("FAIL blank_fall: got %0d required 640", fall); end
    checks++;
    if (first != 656 || last != 751 || cnt != 96) begin
      errors++; $display("FAIL hs_window: got %0d..%0d n=%0d required 656..751 n=96", first, last, cnt);
    end
  endtask

  task automatic test_frames;
    int cyc = 0, lastp = 0, pulses = 0;
    bit vs_low[SVT];
    for (int y = 0; y < SVT; y++) vs_low[y] = 1'b0;
    tick(1'b1, rnd(), 1'b0, 1'b1);
    tick(1'b1, rnd(), 1'b1, 1'b1);
    checks++;
    if (fs_s !== 1'b1) begin errors++; $display("FAIL frames_first_pulse: got %b required 1", fs_s); end
    for (int i = 0; i < 2 * SFRAME + 10 && pulses < 2; i++) begin
      tick(1'b1, rnd(), 1'b1, 1'b1);
      cyc++;
      checks++;
      if (got_vec(1) !== exp_vec(1)) begin
        errors++; $display("FAIL frames_model: got %h required %h", got_vec(1), exp_vec(1));
      end
      if (!vs_s) vs_low[y_s] = 1'b1;
      if (fs_s) begin
        pulses++;
        checks++;
        if (cyc - lastp != SFRAME) begin
          errors++; $display("FAIL frame_period: got %0d required %0d", cyc - lastp, SFRAME);
        end
        lastp = cyc;
      end
    end
    checks++;
    if (pulses != 2 || fc_s !== 8'd2) begin
      errors++; $display("FAIL frame_count2: got pulses=%0d fc=%0d required 2 2", pulses, fc_s);
    end
    for (int y = 0; y < SVT; y++) begin
      checks++;
      if (vs_low[y] != (y >= 4 && y < 6)) begin
        errors++; $display("FAIL vs_lines: line %0d got low=%b required %b", y, vs_low[y], (y >= 4 && y < 6));
      end
    end
  endtask

  task automatic test_pixen;
    int nxt_cyc = -1;
    logic [9:0] px;
    tick(1'b1, rnd(), 1'b0, 1'b1);
    tick(1'b1, rnd(), 1'b1, 1'b1);
    for (int i = 1; i < 3 * SFRAME && nxt_cyc < 0; i++) begin
      px = x_s;
      tick(1'b1, rnd(), 1'b1, (i % 2) == 0);
      checks++;
      if (got_vec(1) !== exp_vec(1)) begin
        errors++; $display("FAIL pixen_model: got %h required %h", got_vec(1), exp_vec(1));
      end
      if ((i % 2) == 1) begin
        checks++;
        if (x_s !== px || fs_s !== 1'b0) begin
          errors++; $display("FAIL pixen_hold: got x=%0d fs=%b required x=%0d fs=0", x_s, fs_s, px);
        end
      end
      if (fs_s) nxt_cyc = i;
    end
    checks++;
    if (nxt_cyc != 2 * SFRAME) begin
      errors++; $display("FAIL pixen_period: got %0d required %0d", nxt_cyc, 2 * SFRAME);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 49) != 0, rnd(), $urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0);
      checks++;
      if (got_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL random_dflt: got %h required %h", got_vec(0), exp_vec(0));
      end
      checks++;
      if (got_vec(1) !== exp_vec(1)) begin
        errors++; $display("FAIL random_sml: got %h required %h", got_vec(1), exp_vec(1));
      end
    end
  endtask

  task automatic test_mid_reset;
    bit found = 1'b0;
    tick(1'b1, rnd(), 1'b0, 1'b1);
    for (int i = 0; i < 8 * SFRAME && !found; i++) begin
      tick(1'b1, rnd(), 1'b1, 1'b1);
      if (fc_s == 8'd5 && x_s == 10'd7 && y_s == 10'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_reset_reach: got no (7,3,fc5) required reached"); end
    tick(1'b1, rnd(), 1'b0, rnd());
    checks++;
    if ({x_s, y_s, fc_s, hs_s, vs_s, fs_s} !== {10'd0, 10'd0, 8'd0, 3'b110}) begin
      errors++;
      $display("FAIL mid_reset: got x=%0d y=%0d fc=%0d hs=%b vs=%b fs=%b required 0 0 0 1 1 0",
               x_s, y_s, fc_s, hs_s, vs_s, fs_s);
    end
    tick(1'b1, rnd(), 1'b1, 1'b1);
    checks++;
    if ({x_s, y_s, fc_s, fs_s} !== {10'd0, 10'd0, 8'd0, 1'b1}) begin
      errors++; $display("FAIL mid_reset_restart: got x=%0d y=%0d fc=%0d fs=%b required 0 0 0 1",
                         x_s, y_s, fc_s, fs_s);
    end
  endtask

  task automatic test_fc_wrap;
    bit found = 1'b0;
    for (int i = 0; i < 257 * SFRAME && !found; i++) begin
      tick(1'b1, rnd(), 1'b1, 1'b1);
      checks++;
      if (got_vec(1) !== exp_vec(1)) begin
        errors++; $display("FAIL wrap_model: got %h required %h", got_vec(1), exp_vec(1));
      end
      if (fc_s == 8'd255 && x_s == 10'(SHT - 1) && y_s == 10'(SVT - 1)) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL fc_wrap_reach: got no fc=255 at last pixel required reached"); end
    tick(1'b1, rnd(), 1'b1, 1'b1);
    checks++;
    if ({x_s, y_s, fc_s, fs_s} !== {10'd0, 10'd0, 8'd0, 1'b1}) begin
      errors++; $display("FAIL fc_wrap: got x=%0d y=%0d fc=%0d fs=%b required 0 0 0 1", x_s, y_s, fc_s, fs_s);
    end
  endtask

  initial begin
    rn_d = 1'b0; pe_d = 1'b0; rn_s = 1'b0; pe_s = 1'b0;
    test_reset();
    test_line();
    test_frames();
    test_pixen();
    test_random();
    test_mid_reset();
    test_fc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
